// File: rtl/apb_reg_completer.sv
// APB completer fronting a small register bank: NUM_REGS-1 RW control registers plus one
// RO status register, with a fixed number of wait states and error responses on bad accesses.
module apb_reg_completer #(
  parameter int                 ADDR_W      = 32,
  parameter int                 DATA_W      = 32,
  parameter int                 NUM_REGS    = 8,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
  parameter int                 WAIT_STATES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          apb_paddr,
  input  logic                       apb_psel,
  input  logic                       apb_penable,
  input  logic                       apb_pwrite,
  input  logic [DATA_W-1:0]          apb_pwdata,
  output logic                       apb_pready,
  output logic [DATA_W-1:0]          apb_prdata,
  output logic                       apb_pslverr,
  input  logic [DATA_W-1:0]          status_in,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr_pulse
);

  localparam int                IDX_W      = $clog2(NUM_REGS);
  localparam int                RO_IDX     = NUM_REGS - 1;
  localparam logic [IDX_W-1:0]  RO_IDX_I   = IDX_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);
  localparam logic [ADDR_W-1:0] NREGS_A    = ADDR_W'(NUM_REGS);
  localparam logic [3:0]        WAIT_INIT  = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic [IDX_W-1:0]    idx_q;
  logic                wr_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pulse_q;

  logic [ADDR_W-1:0]   off;
  logic [ADDR_W-1:0]   idx_full;
  logic [IDX_W-1:0]    dec_idx;
  logic                dec_err;
  logic                setup;
  logic                ready;
  logic                done;
  logic                commit;

  // Address decode, evaluated during the setup phase only
  always_comb begin
    off      = apb_paddr - BASE_ADDR;
    idx_full = off / WORD_BYTES;
    dec_idx  = idx_full[IDX_W-1:0];
    dec_err  = (apb_paddr < BASE_ADDR) || (idx_full >= NREGS_A) ||
               ((off % WORD_BYTES) != '0) || (apb_pwrite && (dec_idx == RO_IDX_I));
  end

  assign setup  = (state == IDLE) && apb_psel && !apb_penable;
  assign ready  = (state == ACCESS) && (cnt == 4'd0);
  assign done   = ready && apb_psel && apb_penable;
  assign commit = done && wr_q && !err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    apb_pready  = 1'b0;
    apb_pslverr = 1'b0;
    apb_prdata  = '0;
    case (state)
      IDLE: begin
        if (setup) state_nxt = ACCESS;
      end
      ACCESS: begin
        apb_pready  = ready;
        apb_pslverr = ready && err_q;
        apb_prdata  = ready ? rdata_q : '0;
        if (!apb_psel || done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data is captured at setup; illegal or write accesses return zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      pulse_q <= '0;
      if (setup) begin
        cnt   <= WAIT_INIT;
        idx_q <= dec_idx;
        wr_q  <= apb_pwrite;
        err_q <= dec_err;
        if (dec_err || apb_pwrite)    rdata_q <= '0;
        else if (dec_idx == RO_IDX_I) rdata_q <= status_in;
        else                          rdata_q <= regs[dec_idx];
      end else if ((state == ACCESS) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        regs[idx_q]    <= apb_pwdata;
        pulse_q[idx_q] <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
    assign reg_q[i*DATA_W +: DATA_W] = (i == RO_IDX) ? '0 : regs[i];
  end

  assign reg_wr_pulse = pulse_q;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Scoreboard bench: three completers (0, 1 and 3 wait states) on a shared APB bus with
// per-instance select; a negedge monitor checks every response and the write side effects.
module tb_apb_reg_completer;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NR   = 8;
  localparam logic [31:0] BASE = 32'h1000;

  typedef struct {
    int          dut;
    int          waits;
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  pulse;
    int          idx;
    logic [31:0] val;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     paddr;
  logic [2:0]        psel;
  logic              penable;
  logic              pwrite;
  logic [DW-1:0]     pwdata;
  logic [DW-1:0]     status_in;
  logic              pready  [3];
  logic              pslverr [3];
  logic [DW-1:0]     prdata  [3];
  logic [NR*DW-1:0]  regq    [3];
  logic [NR-1:0]     pulse   [3];

  int   checks = 0;
  int   passed = 0;
  int   cyc    = 0;
  exp_t sb[$];
  exp_t pend_e;
  exp_t mon_e;
  logic pend = 1'b0;
  int   acc [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_reg_completer #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_STATES(1)) u0 (
    .clk(clk), .rst(rst), .apb_paddr(paddr), .apb_psel(psel[0]), .apb_penable(penable),
    .apb_pwrite(pwrite), .apb_pwdata(pwdata), .apb_pready(pready[0]), .apb_prdata(prdata[0]),
    .apb_pslverr(pslverr[0]), .status_in(status_in), .reg_q(regq[0]), .reg_wr_pulse(pulse[0]));

  apb_reg_completer #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_STATES(0)) u1 (
    .clk(clk), .rst(rst), .apb_paddr(paddr), .apb_psel(psel[1]), .apb_penable(penable),
    .apb_pwrite(pwrite), .apb_pwdata(pwdata), .apb_pready(pready[1]), .apb_prdata(prdata[1]),
    .apb_pslverr(pslverr[1]), .status_in(status_in), .reg_q(regq[1]), .reg_wr_pulse(pulse[1]));

  apb_reg_completer #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_STATES(3)) u2 (
    .clk(clk), .rst(rst), .apb_paddr(paddr), .apb_psel(psel[2]), .apb_penable(penable),
    .apb_pwrite(pwrite), .apb_pwdata(pwdata), .apb_pready(pready[2]), .apb_prdata(prdata[2]),
    .apb_pslverr(pslverr[2]), .status_in(status_in), .reg_q(regq[2]), .reg_wr_pulse(pulse[2]));

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: side effects one cycle after each completion, then any new response
  always @(negedge clk) begin
    if (pend) begin
      chk("wr_pulse", pulse[pend_e.dut], pend_e.pulse);
      chk("reg_q", regq[pend_e.dut][pend_e.idx*DW +: DW], pend_e.val);
      pend = 1'b0;
    end
    for (int d = 0; d < 3; d++) begin
      if (psel[d] && !penable) acc[d] = 0;
      else if (psel[d] && penable) acc[d]++;
      if (pready[d]) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_response: dut %0d pready=1 with no transfer expected", d);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_dut", d, mon_e.dut);
          chk("latency", acc[d], mon_e.waits);
          chk("pslverr", pslverr[d], mon_e.err);
          chk("prdata", prdata[d], mon_e.rdata);
          pend_e = mon_e;
          pend   = 1'b1;
        end
      end
    end
  end

  // One complete transfer; called and returns at posedge+1
  task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input int w, input logic er, input logic [31:0] rd,
                      input logic [7:0] pl, input int ix, input logic [31:0] v);
    exp_t e;
    e.dut = d; e.waits = w; e.err = er; e.rdata = rd; e.pulse = pl; e.idx = ix; e.val = v;
    sb.push_back(e);
    paddr = a; pwrite = wr; pwdata = wd; psel[d] = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      if (pready[d]) break;
      if (n == 40) begin
        checks++;
        $display("FAIL timeout: dut %0d addr %h no pready within 40 cycles", d, a);
      end
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int start;
    rst = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; status_in = '0;
    for (int d = 0; d < 3; d++) acc[d] = 0;
    repeat (2) @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_pready", pready[d], 1'b0);
      chk("rst_pslverr", pslverr[d], 1'b0);
      chk("rst_prdata", prdata[d], 32'h0);
      chk("rst_reg_q", regq[d], '0);
      chk("rst_pulse", pulse[d], 8'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // penable without a preceding setup phase must be ignored
    psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = BASE + 32'h4; pwdata = 32'h0BAD;
    repeat (2) begin
      @(negedge clk);
      chk("no_setup_pready", pready[0], 1'b0);
    end
    @(posedge clk); #1;
    psel[0] = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("no_setup_reg_q", regq[0], '0);
    @(posedge clk); #1;

    // one wait state: writes, reads, status and error cases
    xfer(0, 1'b1, BASE + 32'h4,  32'hDEADBEEF, 2, 1'b0, 32'h0,        8'b0000_0010, 1, 32'hDEADBEEF);
    xfer(0, 1'b0, BASE + 32'h4,  32'h0,        2, 1'b0, 32'hDEADBEEF, 8'h00,        1, 32'hDEADBEEF);
    status_in = 32'h1234;
    xfer(0, 1'b0, BASE + 32'h1C, 32'h0,        2, 1'b0, 32'h00001234, 8'h00,        7, 32'h0);
    xfer(0, 1'b1, BASE + 32'h1C, 32'hFFFFFFFF, 2, 1'b1, 32'h0,        8'h00,        7, 32'h0);
    xfer(0, 1'b0, BASE + 32'h20, 32'h0,        2, 1'b1, 32'h0,        8'h00,        1, 32'hDEADBEEF);
    xfer(0, 1'b0, BASE + 32'h6,  32'h0,        2, 1'b1, 32'h0,        8'h00,        1, 32'hDEADBEEF);
    xfer(0, 1'b1, BASE - 32'h4,  32'h1,        2, 1'b1, 32'h0,        8'h00,        0, 32'h0);
    xfer(0, 1'b1, BASE + 32'h6,  32'h5,        2, 1'b1, 32'h0,        8'h00,        1, 32'hDEADBEEF);

    // zero wait states, back to back
    start = cyc;
    xfer(1, 1'b1, BASE + 32'h0, 32'hA0, 1, 1'b0, 32'h0, 8'b0000_0001, 0, 32'hA0);
    xfer(1, 1'b1, BASE + 32'h4, 32'hA1, 1, 1'b0, 32'h0, 8'b0000_0010, 1, 32'hA1);
    xfer(1, 1'b1, BASE + 32'h8, 32'hA2, 1, 1'b0, 32'h0, 8'b0000_0100, 2, 32'hA2);
    chk("b2b_cycles", cyc - start, 6);
    xfer(1, 1'b0, BASE + 32'h8, 32'h0,  1, 1'b0, 32'hA2, 8'h00, 2, 32'hA2);

    // three wait states: psel dropped in the first access cycle
    paddr = BASE + 32'h8; pwrite = 1'b1; pwdata = 32'h55; psel[2] = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    psel[2] = 1'b0;
    @(negedge clk);
    chk("abort_pready", pready[2], 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_pulse", pulse[2], 8'h00);
    chk("abort_reg_q", regq[2][2*DW +: DW], 32'h0);
    @(posedge clk); #1;
    xfer(2, 1'b1, BASE + 32'h8, 32'h66, 4, 1'b0, 32'h0,  8'b0000_0100, 2, 32'h66);
    xfer(2, 1'b0, BASE + 32'h8, 32'h0,  4, 1'b0, 32'h66, 8'h00,        2, 32'h66);

    // reset during the completing access cycle of a write
    paddr = BASE + 32'h8; pwrite = 1'b1; pwdata = 32'h77; psel[0] = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #2;
    chk("pre_rst_pready", pready[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_pready", pready[0], 1'b0);
    for (int d = 0; d < 3; d++) chk("mid_rst_reg_q", regq[d], '0);
    psel[0] = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    xfer(0, 1'b1, BASE + 32'h8, 32'h88, 2, 1'b0, 32'h0, 8'b0000_0100, 2, 32'h88);
    xfer(0, 1'b0, BASE + 32'h4, 32'h0,  2, 1'b0, 32'h0, 8'h00,        1, 32'h0);

    for (int i = 0; i < 50 && (sb.size() != 0 || pend); i++) @(posedge clk);
    if (sb.size() != 0 || pend) begin
      checks++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
